// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer.
// FSM state values and the hardwired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use stall, branch flush, memory wait, watchdog.
// Optional PIPE_PERF_CNT_EN adds stall_cycles_o / flush_cnt_o counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_ex_memread_i,
  input  logic [4:0]  id_ex_rt_i,
  input  logic [4:0]  if_id_rs_i,
  input  logic [4:0]  if_id_rt_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        ex_mem_write_o,
  output logic        mem_wb_bubble_o,
  output logic        mem_busy_o,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        mem_err_o
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);
  localparam logic             WD_EN   = (MEM_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_stall;
  logic freeze;
  logic hazard;
  logic luse;
  logic flush;

  assign mem_stall = mem_req_i & ~mem_ready_i;
  assign freeze    = (state_q == ERR) | mem_stall;
  assign hazard    = id_ex_memread_i
                   & (id_ex_rt_i != REG_ZERO)
                   & ((id_ex_rt_i == if_id_rs_i)
                    | (id_ex_rt_i == if_id_rt_i));
  assign luse      = ~freeze & hazard;
  assign flush     = ~freeze & ~luse & branch_taken_i;

  // State and wait-counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and watchdog counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        cnt_d = '0;
        if (mem_stall) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_req_i || mem_ready_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (WD_EN && cnt_q == TIMEOUT) begin
          state_d = ERR;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage-register controls, priority reset > freeze > luse > flush
  always_comb begin
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_write_o  = 1'b1;
    mem_wb_bubble_o = 1'b0;
    mem_busy_o      = 1'b0;
    mem_err_o       = 1'b0;
    if (rst_i) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_bubble_o  = 1'b1;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (freeze) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      ex_mem_write_o  = 1'b0;
      mem_wb_bubble_o = 1'b1;
      mem_busy_o      = 1'b1;
      mem_err_o       = (state_q == ERR);
    end else if (luse) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      id_ex_bubble_o  = 1'b1;
    end else if (flush) begin
      if_id_flush_o   = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] fcnt_q, fcnt_d;

  // Saturating performance counter next values
  always_comb begin
    stall_d = stall_q;
    fcnt_d  = fcnt_q;
    if ((freeze || luse) && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush && fcnt_q != '1) begin
      fcnt_d = fcnt_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      fcnt_q  <= '0;
    end else begin
      stall_q <= stall_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_cnt_o    = fcnt_q;
`endif

endmodule
